// File: rtl/spi_packet_assembler_buffered_pkg.sv
// Shared types and helpers for the SPI packet assembler datapath.
package spi_packet_assembler_buffered_pkg;

    // Fill-stage FSM: FILL accepts fragments, HELD parks a finished packet.
    typedef enum logic {
        FILL = 1'b0,
        HELD = 1'b1
    } fill_state_e;

    // Integer ceiling division, used to size the slot array.
    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/spi_packet_out_buffer.sv
// Single-entry val/rdy output register with simultaneous take and load.
module spi_packet_out_buffer #(
    parameter int unsigned msg_w = 32,
    parameter int unsigned len_w = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [msg_w-1:0] load_msg,
    input  logic [len_w-1:0] load_len,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic [msg_w-1:0] resp_msg,
    output logic [len_w-1:0] resp_len,
    output logic             free_c
);

    // The entry can accept a packet when empty or being drained this cycle.
    assign free_c = ~resp_val | resp_rdy;

    // Load wins over take so a back-to-back packet keeps resp_val high.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_val <= 1'b0;
            resp_msg <= '0;
            resp_len <= '0;
        end else if (load) begin
            resp_val <= 1'b1;
            resp_msg <= load_msg;
            resp_len <= load_len;
        end else if (resp_val && resp_rdy) begin
            resp_val <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_packet_assembler_buffered.sv
// Assembles nbits_in fragments into nbits_out packets with early termination
// and a one-packet output buffer so filling continues while output stalls.
module spi_packet_assembler_buffered
    import spi_packet_assembler_buffered_pkg::*;
#(
    parameter int unsigned nbits_in  = 8,
    parameter int unsigned nbits_out = 32,
    parameter bit          msb_first = 1'b1
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               req_val,
    output logic                                               req_rdy,
    input  logic [nbits_in-1:0]                                req_msg,
    input  logic                                               req_last,
    output logic                                               resp_val,
    input  logic                                               resp_rdy,
    output logic [nbits_out-1:0]                               resp_msg,
    output logic [$clog2(ceil_div(nbits_out, nbits_in)):0]     resp_len
);

    localparam int unsigned num_regs = ceil_div(nbits_out, nbits_in);
    localparam int unsigned len_w    = $clog2(num_regs) + 1;
    localparam int unsigned cat_w    = num_regs * nbits_in;

    fill_state_e          state;
    fill_state_e          state_next;
    logic [nbits_in-1:0]  slots      [num_regs];
    logic [nbits_in-1:0]  slots_next [num_regs];
    logic [len_w-1:0]     cnt;
    logic [len_w-1:0]     fill_cnt;
    logic                 accept;
    logic                 complete;
    logic                 move;
    logic                 buf_free_c;
    logic [cat_w-1:0]     cat;
    logic [nbits_out-1:0] packed_msg;
    logic                 unused_cat;

    // Ready is a pure decode of the state register.
    assign req_rdy  = (state == FILL);
    assign accept   = req_val & req_rdy;
    assign complete = accept & (req_last | (cnt == len_w'(num_regs - 1)));
    assign fill_cnt = accept ? cnt + len_w'(1) : cnt;

    // Slot contents after this cycle's fragment, so a completing fragment moves with its packet.
    always_comb begin
        for (int k = 0; k < int'(num_regs); k++) begin
            slots_next[k] = (accept && (cnt == len_w'(k))) ? req_msg : slots[k];
        end
    end

    // Place slots into the concatenation in the selected order, then truncate.
    always_comb begin
        cat = '0;
        for (int k = 0; k < int'(num_regs); k++) begin
            if (msb_first) begin
                cat[(int'(num_regs) - 1 - k) * int'(nbits_in) +: nbits_in] = slots_next[k];
            end else begin
                cat[k * int'(nbits_in) +: nbits_in] = slots_next[k];
            end
        end
    end

    assign packed_msg = cat[nbits_out-1:0];
    assign unused_cat = ^cat;

    // Fill FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and move decision: hand the packet over whenever the buffer can take it.
    always_comb begin
        state_next = state;
        move       = 1'b0;
        case (state)
            FILL: begin
                if (complete) begin
                    if (buf_free_c) begin
                        move = 1'b1;
                    end else begin
                        state_next = HELD;
                    end
                end
            end
            HELD: begin
                if (buf_free_c) begin
                    move       = 1'b1;
                    state_next = FILL;
                end
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    // Slot and counter update; a move empties the fill stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < int'(num_regs); k++) begin
                slots[k] <= '0;
            end
            cnt <= '0;
        end else if (move) begin
            for (int k = 0; k < int'(num_regs); k++) begin
                slots[k] <= '0;
            end
            cnt <= '0;
        end else begin
            for (int k = 0; k < int'(num_regs); k++) begin
                slots[k] <= slots_next[k];
            end
            cnt <= fill_cnt;
        end
    end

    spi_packet_out_buffer #(
        .msg_w (nbits_out),
        .len_w (len_w)
    ) u_out_buffer (
        .clk      (clk),
        .reset    (reset),
        .load     (move),
        .load_msg (packed_msg),
        .load_len (fill_cnt),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_msg (resp_msg),
        .resp_len (resp_len),
        .free_c   (buf_free_c)
    );

endmodule
